// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
// line_pkg
// State encoding for the line packer.
// Revision: 1.0
// ============================================================================
package line_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/sssp_pkg.sv
`default_nettype none
// ============================================================================
// sssp_pkg
// Shared SSSP datapath types and the lane-valid thermometer decoder.
// Revision: 1.0
// ============================================================================
package sssp_pkg;

  localparam int WORD_W = 64;
  localparam int LANES  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LANES-1:0]  lane_mask_t;

  typedef struct packed {
    logic [2:0] cnt;
    logic       legal;
  } therm_t;

  // Counts consecutive ones from lane 0; legal only for a pure thermometer code.
  function automatic therm_t therm_cnt(input lane_mask_t m);
    therm_t     r;
    lane_mask_t v_ref;
    r.cnt = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i] && (r.cnt == 3'(i))) r.cnt = r.cnt + 3'd1;
    end
    v_ref = '0;
    for (int i = 0; i < LANES; i++) begin
      v_ref[i] = (3'(i) < r.cnt);
    end
    r.legal = (m == v_ref);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_packer.sv
`default_nettype none
// ============================================================================
// line_packer
// Packs compacted 4-lane bundles into dense 4-word lines; flushes on end of pass.
// Revision: 1.0
// ============================================================================
module line_packer #(
  parameter int WORD_W = 64,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    last_input_in,
  input  logic [LANES-1:0]        word_in_valid,
  input  logic [LANES*WORD_W-1:0] word_in,
  output logic                    line_out_valid,
  output logic [LANES-1:0]        line_out_mask,
  output logic [LANES*WORD_W-1:0] line_out,
  output logic                    last_output,
  output logic [31:0]             words_out,
  output logic                    protocol_err
);

  import sssp_pkg::*;
  import line_pkg::*;

  localparam int c_COMB = 2*LANES - 1;

  packer_state_t           r_state, w_state_nxt;
  logic [1:0]              r_buf_cnt, w_buf_cnt_nxt;
  logic [WORD_W-1:0]       r_buf      [LANES-1];
  logic [WORD_W-1:0]       w_buf_nxt  [LANES-1];
  logic [WORD_W-1:0]       w_comb     [c_COMB];
  therm_t                  w_in;
  logic [2:0]              w_in_cnt;
  logic [2:0]              w_n;
  logic                    w_valid_nxt;
  logic                    w_last_nxt;
  logic                    w_err_set;
  logic [LANES-1:0]        w_mask_nxt;
  logic [LANES*WORD_W-1:0] w_line_nxt;
  logic [31:0]             w_words_nxt;

  function automatic logic [LANES-1:0] thermo(input logic [2:0] n);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (3'(i) < n);
    return m;
  endfunction

  // Combined sequence: buffered words first, then accepted input lanes.
  always_comb begin
    w_in     = therm_cnt(word_in_valid);
    w_in_cnt = (r_state == FLUSH) ? 3'd0 : w_in.cnt;
    w_n      = 3'(r_buf_cnt) + w_in_cnt;
    for (int i = 0; i < c_COMB; i++) w_comb[i] = '0;
    for (int j = 0; j < LANES; j++) begin
      if (3'(j) < w_in_cnt) w_comb[3'(j) + 3'(r_buf_cnt)] = word_in[j*WORD_W +: WORD_W];
    end
    for (int i = 0; i < LANES-1; i++) begin
      if (2'(i) < r_buf_cnt) w_comb[i] = r_buf[i];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_cnt_nxt = r_buf_cnt;
    w_valid_nxt   = 1'b0;
    w_last_nxt    = 1'b0;
    w_mask_nxt    = '0;
    w_err_set     = 1'b0;
    for (int k = 0; k < LANES-1; k++) w_buf_nxt[k] = w_comb[k+LANES];

    case (r_state)
      RUN: begin
        w_err_set = !w_in.legal;
        if (last_input_in) begin
          if (w_n > 3'(LANES)) begin
            w_valid_nxt   = 1'b1;
            w_mask_nxt    = '1;
            w_buf_cnt_nxt = 2'(w_n - 3'(LANES));
            w_state_nxt   = FLUSH;
          end else begin
            w_valid_nxt   = (w_n != 3'd0);
            w_last_nxt    = 1'b1;
            w_mask_nxt    = thermo(w_n);
            w_buf_cnt_nxt = 2'd0;
          end
        end else if (w_n >= 3'(LANES)) begin
          w_valid_nxt   = 1'b1;
          w_mask_nxt    = '1;
          w_buf_cnt_nxt = 2'(w_n - 3'(LANES));
        end else begin
          w_buf_cnt_nxt = 2'(w_n);
          for (int k = 0; k < LANES-1; k++) w_buf_nxt[k] = w_comb[k];
        end
      end
      FLUSH: begin
        // Inputs are ignored here, so the combined sequence is exactly buf.
        w_err_set     = (word_in_valid != '0) || last_input_in;
        w_valid_nxt   = 1'b1;
        w_last_nxt    = 1'b1;
        w_mask_nxt    = thermo(w_n);
        w_buf_cnt_nxt = 2'd0;
        w_state_nxt   = RUN;
      end
      default: w_state_nxt = RUN;
    endcase

    for (int k = 0; k < LANES; k++) begin
      w_line_nxt[k*WORD_W +: WORD_W] = w_mask_nxt[k] ? w_comb[k] : '0;
    end
    w_words_nxt = (last_output ? 32'd0 : words_out) + 32'($countones(w_mask_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_buf_cnt      <= 2'd0;
      for (int k = 0; k < LANES-1; k++) r_buf[k] <= '0;
      line_out_valid <= 1'b0;
      line_out_mask  <= '0;
      line_out       <= '0;
      last_output    <= 1'b0;
      words_out      <= 32'd0;
      protocol_err   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_buf_cnt      <= w_buf_cnt_nxt;
      for (int k = 0; k < LANES-1; k++) r_buf[k] <= w_buf_nxt[k];
      line_out_valid <= w_valid_nxt;
      line_out_mask  <= w_mask_nxt;
      line_out       <= w_line_nxt;
      last_output    <= w_last_nxt;
      words_out      <= w_words_nxt;
      protocol_err   <= protocol_err | w_err_set;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_packer.sv
`default_nettype none
// ============================================================================
// tb_line_packer
// Directed bench with a queue-based reference model and per-cycle compare.
// Revision: 1.0
// ============================================================================
module tb_line_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         last_input_in = 1'b0;
  logic [3:0]   word_in_valid = 4'b0;
  logic [255:0] word_in = '0;
  logic         line_out_valid;
  logic [3:0]   line_out_mask;
  logic [255:0] line_out;
  logic         last_output;
  logic [31:0]  words_out;
  logic         protocol_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  line_packer #(.WORD_W(64), .LANES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .last_input_in  (last_input_in),
    .word_in_valid  (word_in_valid),
    .word_in        (word_in),
    .line_out_valid (line_out_valid),
    .line_out_mask  (line_out_mask),
    .line_out       (line_out),
    .last_output    (last_output),
    .words_out      (words_out),
    .protocol_err   (protocol_err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a word queue; lines leave in groups of four.
  logic         exp_valid = 1'b0;
  logic [3:0]   exp_mask = '0;
  logic [255:0] exp_line = '0;
  logic         exp_last = 1'b0;
  logic [31:0]  exp_words = '0;
  logic         exp_err = 1'b0;
  logic [63:0]  q[$];
  bit           flush_pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int k;
    int emit;
    logic [31:0] base;
    if (!rst_n) begin
      q.delete();
      flush_pend = 1'b0;
      exp_valid = 1'b0; exp_mask = '0; exp_line = '0;
      exp_last = 1'b0;  exp_words = '0; exp_err = 1'b0;
    end else begin
      base = exp_last ? 32'd0 : exp_words;
      exp_valid = 1'b0; exp_mask = '0; exp_line = '0; exp_last = 1'b0;
      emit = 0;
      if (flush_pend) begin
        if (word_in_valid != 4'b0 || last_input_in) exp_err = 1'b1;
        emit = q.size();
        flush_pend = 1'b0;
        exp_last = 1'b1;
      end else begin
        k = 0;
        while (k < 4 && word_in_valid[k]) k++;
        if (!(word_in_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) exp_err = 1'b1;
        for (int i = 0; i < k; i++) q.push_back(word_in[i*64 +: 64]);
        if (last_input_in) begin
          flush_pend = (q.size() > 4);
          exp_last   = (q.size() <= 4);
          emit       = (q.size() > 4) ? 4 : q.size();
        end else if (q.size() >= 4) begin
          emit = 4;
        end
      end
      for (int i = 0; i < emit; i++) begin
        exp_line[i*64 +: 64] = q.pop_front();
        exp_mask[i] = 1'b1;
      end
      exp_valid = (emit > 0);
      exp_words = base + 32'(emit);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", 256'(line_out_valid), 256'(exp_valid));
      check("cyc_mask",  256'(line_out_mask),  256'(exp_mask));
      check("cyc_line",  line_out,             exp_line);
      check("cyc_last",  256'(last_output),    256'(exp_last));
      check("cyc_words", 256'(words_out),      256'(exp_words));
      check("cyc_err",   256'(protocol_err),   256'(exp_err));
    end
  end

  function automatic logic [63:0] wd(input logic [15:0] tag, input int i);
    return {tag, 48'(i)};
  endfunction

  function automatic logic [63:0] lane(input int i);
    return line_out[i*64 +: 64];
  endfunction

  task automatic drive(input logic [3:0] v, input logic [15:0] tag, input bit last);
    @(negedge clk);
    word_in_valid = v;
    word_in       = {wd(tag, 3), wd(tag, 2), wd(tag, 1), wd(tag, 0)};
    last_input_in = last;
  endtask

  task automatic idle(input bit last);
    @(negedge clk);
    word_in_valid = 4'b0;
    word_in       = '0;
    last_input_in = last;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 256'(line_out_valid), 256'(0));
    check("rst_line",  line_out,             256'(0));
    check("rst_words", 256'(words_out),      256'(0));
    check("rst_err",   256'(protocol_err),   256'(0));
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Two full bundles back to back
    drive(4'b1111, 16'hA, 0);
    drive(4'b1111, 16'hB, 0);
    check("t1_valid", 256'(line_out_valid), 256'(1));
    check("t1_l0",    256'(lane(0)),        256'(wd(16'hA, 0)));
    check("t1_l3",    256'(lane(3)),        256'(wd(16'hA, 3)));
    check("t1_words", 256'(words_out),      256'(4));
    idle(0);
    check("t1b_l0",    256'(lane(0)),   256'(wd(16'hB, 0)));
    check("t1b_words", 256'(words_out), 256'(8));

    // Partial bundles 0111, 0011, 0111 (W0..W7 across tags 1,2,3)
    drive(4'b0111, 16'h1, 0);
    check("t2_nv0", 256'(line_out_valid), 256'(0));
    drive(4'b0011, 16'h2, 0);
    check("t2_nv1", 256'(line_out_valid), 256'(0));
    drive(4'b0111, 16'h3, 0);
    check("t2_l0",    256'(lane(0)),   256'(wd(16'h1, 0)));
    check("t2_l3",    256'(lane(3)),   256'(wd(16'h2, 0)));
    check("t2_words", 256'(words_out), 256'(12));
    idle(0);
    check("t2b_l0",    256'(lane(0)),   256'(wd(16'h2, 1)));
    check("t2b_l3",    256'(lane(3)),   256'(wd(16'h3, 2)));
    check("t2b_words", 256'(words_out), 256'(16));

    // End of pass with nothing buffered
    idle(1);
    idle(0);
    check("t3_last",  256'(last_output),    256'(1));
    check("t3_valid", 256'(line_out_valid), 256'(0));
    check("t3_words", 256'(words_out),      256'(16));

    // buf=3 then 1111 with last -> full line, then flush of 3
    drive(4'b0111, 16'hC, 0);
    check("t4_words0", 256'(words_out), 256'(0));
    drive(4'b1111, 16'hD, 1);
    idle(0);
    check("t4_mask", 256'(line_out_mask), 256'(4'b1111));
    check("t4_l3",   256'(lane(3)),       256'(wd(16'hD, 0)));
    check("t4_last", 256'(last_output),   256'(0));
    idle(0);
    check("t4f_mask",  256'(line_out_mask), 256'(4'b0111));
    check("t4f_l0",    256'(lane(0)),       256'(wd(16'hD, 1)));
    check("t4f_l3",    256'(lane(3)),       256'(0));
    check("t4f_last",  256'(last_output),   256'(1));
    check("t4f_words", 256'(words_out),     256'(7));

    // 0011 then last with no words
    drive(4'b0011, 16'hE, 0);
    idle(1);
    idle(0);
    check("t5_mask",  256'(line_out_mask), 256'(4'b0011));
    check("t5_l1",    256'(lane(1)),       256'(wd(16'hE, 1)));
    check("t5_l2",    256'(lane(2)),       256'(0));
    check("t5_words", 256'(words_out),     256'(2));

    // Illegal pattern, then input while flushing
    drive(4'b0101, 16'hF, 0);
    drive(4'b1111, 16'h6, 0);
    check("t6_err", 256'(protocol_err), 256'(1));
    drive(4'b1111, 16'h7, 1);
    check("t6_l0", 256'(lane(0)), 256'(wd(16'hF, 0)));
    check("t6_l1", 256'(lane(1)), 256'(wd(16'h6, 0)));
    drive(4'b1111, 16'h9, 1);
    check("t6_l0b", 256'(lane(0)),     256'(wd(16'h6, 3)));
    check("t6_lst", 256'(last_output), 256'(0));
    idle(0);
    check("t6f_mask",  256'(line_out_mask), 256'(4'b0001));
    check("t6f_l0",    256'(lane(0)),       256'(wd(16'h7, 3)));
    check("t6f_words", 256'(words_out),     256'(9));
    idle(0);
    check("t6_ign", 256'(line_out_valid), 256'(0));

    // Asynchronous reset with two words buffered
    drive(4'b0011, 16'h8, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", 256'(line_out_valid), 256'(0));
    check("t7_err",   256'(protocol_err),   256'(0));
    check("t7_words", 256'(words_out),      256'(0));
    @(negedge clk);
    word_in_valid = 4'b0;
    rst_n = 1'b1;
    drive(4'b1111, 16'h5, 0);
    idle(0);
    check("t7_l0",    256'(lane(0)),   256'(wd(16'h5, 0)));
    check("t7_l3",    256'(lane(3)),   256'(wd(16'h5, 3)));
    check("t7_words", 256'(words_out), 256'(4));
    idle(0);
    check("t7_nv", 256'(line_out_valid), 256'(0));
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
